msrv32_lsu_hs: RTL and testbench

//  Parametrised load/store unit replacing the combinational store/load pair in msrv32_top.

---
 rtl/msrv32_lsu_hs_pkg.sv | 12 +
 rtl/msrv32_lsu_hs_align.sv | 35 +++
 rtl/msrv32_lsu_hs.sv | 127 ++++++++++++
 tb/tb_msrv32_lsu_hs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_lsu_hs_pkg.sv
// msrv32_lsu_hs_pkg: shared FSM states, access size codes and the lane-mask helper for the LSU
package msrv32_lsu_hs_pkg;
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_e;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;
    // low (1 << size) bits set: byte enables of an access that starts at lane 0
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        return 8'hff >> (4'd8 - (4'd1 << size));
    endfunction
endpackage

// File: rtl/msrv32_lsu_hs_align.sv
// msrv32_lsu_hs_align: combinational lane shift, byte-enable and load-extend datapath
//   size/uns/off  : access size code, zero-extend flag, byte offset inside the NB-byte word
//   wdata         : LSB-justified store data  -> wdata_sh (2*DW, beat0 low half, beat1 high half)
//   mask          : 2*NB byte enables, beat0 low half, beat1 high half
//   rd_lo/rd_hi   : beat0 / beat1 read words  -> rdata (shifted down and extended)
module msrv32_lsu_hs_align
    import msrv32_lsu_hs_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]              size,
    input  logic                    uns,
    input  logic [$clog2(DW/8)-1:0] off,
    input  logic [DW-1:0]           wdata,
    input  logic [DW-1:0]           rd_lo,
    input  logic [DW-1:0]           rd_hi,
    output logic [2*(DW/8)-1:0]     mask,
    output logic [2*DW-1:0]         wdata_sh,
    output logic [DW-1:0]           rdata
);
    localparam int NB = DW / 8;
    logic [7:0] lm;
    logic unused_lm;
    logic [DW-1:0] v, keep;
    logic sbit;
    assign lm = lane_mask(size);
    assign unused_lm = ^lm;
    assign mask = {{NB{1'b0}}, lm[NB-1:0]} << off;
    assign wdata_sh = {{DW{1'b0}}, wdata} << {off, 3'b000};
    // an access crossing the word boundary reads its upper bytes from the second beat
    assign v = DW'({rd_hi, rd_lo} >> {off, 3'b000});
    assign keep = ~({DW{1'b1}} << (32'd8 << size));
    assign sbit = size == SZ_B ? v[7] : size == SZ_H ? v[15] : size == SZ_W ? v[31] : v[DW-1];
    assign rdata = (v & keep) | ({DW{sbit & ~uns}} & ~keep);
endmodule

// File: rtl/msrv32_lsu_hs.sv
// msrv32_lsu_hs: load/store unit with valid/ready core handshake and req/ack data-memory beats
//   Core side : req_valid_in/req_ready_out accept {we,size,unsigned,addr,wdata};
//               rsp_valid_out pulses once with rsp_rdata_out/rsp_err_out; stall_out while busy;
//               flush_in aborts any outstanding access without a response.
//   Memory    : ms_riscv32_mp_dm{addr,data,wr_mask}_out with dmwr/dmrd_req held until dmack_in;
//               ms_riscv32_mp_dmdata_in is valid in the ack cycle.
//   Define MSRV32_LSU_MISALIGN_SPLIT_EN to serve misaligned accesses (two beats when crossing a
//   word); otherwise they complete at once with rsp_err_out and no bus traffic.
module msrv32_lsu_hs
    import msrv32_lsu_hs_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              ms_riscv32_mp_clk_in,
    input  logic              ms_riscv32_mp_rst_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic              req_we_in,
    input  logic [1:0]        req_size_in,
    input  logic              req_unsigned_in,
    input  logic [AW-1:0]     req_addr_in,
    input  logic [DW-1:0]     req_wdata_in,
    input  logic              flush_in,
    output logic              rsp_valid_out,
    output logic [DW-1:0]     rsp_rdata_out,
    output logic              rsp_err_out,
    output logic              stall_out,
    output logic [AW-1:0]     ms_riscv32_mp_dmaddr_out,
    output logic [DW-1:0]     ms_riscv32_mp_dmdata_out,
    output logic [DW/8-1:0]   ms_riscv32_mp_dmwr_mask_out,
    output logic              ms_riscv32_mp_dmwr_req_out,
    output logic              ms_riscv32_mp_dmrd_req_out,
    input  logic              ms_riscv32_mp_dmack_in,
    input  logic [DW-1:0]     ms_riscv32_mp_dmdata_in
);
    localparam int NB = DW / 8;
    localparam int OW = $clog2(NB);
    lsu_state_e state;
    logic r_we, r_uns, r_split;
    logic [1:0] r_size;
    logic [OW-1:0] r_off;
    logic [DW-1:0] r_wdata, hold;
    logic [31:0] tcnt;
    logic idle, acc_err, acc_split, to_hit;
    logic [2*NB-1:0] mask2;
    logic [2*DW-1:0] wsh;
    logic [DW-1:0] rdata_al;
    assign idle = state == IDLE;
    assign req_ready_out = idle;
    assign stall_out = !idle;
    assign to_hit = TIMEOUT_CYC != 0 && tcnt + 32'd1 == 32'(TIMEOUT_CYC);
`ifdef MSRV32_LSU_MISALIGN_SPLIT_EN
    assign acc_err = DW == 32 && req_size_in == SZ_D;
    assign acc_split = 32'(req_addr_in[OW-1:0]) + (32'd1 << req_size_in) > 32'(NB);
`else
    assign acc_err = (DW == 32 && req_size_in == SZ_D) ||
                     ((req_addr_in[2:0] & ~(3'b111 << req_size_in)) != 3'b000);
    assign acc_split = 1'b0;
`endif
    // in IDLE the datapath works on the incoming request so beat0 can be registered at acceptance
    msrv32_lsu_hs_align #(.DW(DW)) u_align (
        .size     (idle ? req_size_in : r_size),
        .uns      (idle ? req_unsigned_in : r_uns),
        .off      (idle ? req_addr_in[OW-1:0] : r_off),
        .wdata    (idle ? req_wdata_in : r_wdata),
        .rd_lo    (state == BEAT1 ? hold : ms_riscv32_mp_dmdata_in),
        .rd_hi    (ms_riscv32_mp_dmdata_in),
        .mask     (mask2),
        .wdata_sh (wsh),
        .rdata    (rdata_al)
    );
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state <= IDLE;
            {r_we, r_uns, r_split, r_size, r_off, r_wdata, hold, tcnt} <= '0;
            {rsp_valid_out, rsp_err_out, rsp_rdata_out} <= '0;
            {ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmrd_req_out} <= '0;
            {ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmwr_mask_out} <= '0;
        end else if (flush_in) begin
            state <= IDLE;
            {rsp_valid_out, rsp_err_out, rsp_rdata_out} <= '0;
            {ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmrd_req_out} <= '0;
            {ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmwr_mask_out} <= '0;
        end else begin
            {rsp_valid_out, rsp_err_out, rsp_rdata_out} <= '0;
            case (state)
                IDLE: if (req_valid_in) begin
                    {r_we, r_uns, r_size, r_wdata} <= {req_we_in, req_unsigned_in, req_size_in, req_wdata_in};
                    r_off <= req_addr_in[OW-1:0];
                    r_split <= acc_split;
                    tcnt <= '0;
                    if (acc_err) begin
                        state <= RESP;
                        {rsp_valid_out, rsp_err_out} <= 2'b11;
                    end else begin
                        state <= BEAT0;
                        ms_riscv32_mp_dmaddr_out <= {req_addr_in[AW-1:OW], {OW{1'b0}}};
                        ms_riscv32_mp_dmdata_out <= wsh[DW-1:0];
                        ms_riscv32_mp_dmwr_mask_out <= mask2[NB-1:0];
                        ms_riscv32_mp_dmwr_req_out <= req_we_in;
                        ms_riscv32_mp_dmrd_req_out <= !req_we_in;
                    end
                end
                BEAT0, BEAT1: if (ms_riscv32_mp_dmack_in && state == BEAT0 && r_split) begin
                    state <= BEAT1;
                    hold <= ms_riscv32_mp_dmdata_in;
                    tcnt <= '0;
                    ms_riscv32_mp_dmaddr_out <= ms_riscv32_mp_dmaddr_out + AW'(NB);
                    ms_riscv32_mp_dmdata_out <= wsh[2*DW-1:DW];
                    ms_riscv32_mp_dmwr_mask_out <= mask2[2*NB-1:NB];
                end else if (ms_riscv32_mp_dmack_in || to_hit) begin
                    state <= RESP;
                    rsp_valid_out <= 1'b1;
                    rsp_err_out <= !ms_riscv32_mp_dmack_in;
                    rsp_rdata_out <= ms_riscv32_mp_dmack_in && !r_we ? rdata_al : '0;
                    {ms_riscv32_mp_dmwr_req_out, ms_riscv32_mp_dmrd_req_out} <= '0;
                    {ms_riscv32_mp_dmaddr_out, ms_riscv32_mp_dmdata_out, ms_riscv32_mp_dmwr_mask_out} <= '0;
                end else begin
                    tcnt <= tcnt + 32'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msrv32_lsu_hs.sv
// tb_msrv32_lsu_hs: randomized LSU bench against a byte-level memory model and literal anchors
module tb_msrv32_lsu_hs;
    localparam int TO = 4;
    logic clk = 0, rst = 1, req_valid = 0, req_we = 0, req_uns = 0, flush = 0, ack = 0;
    logic [1:0] req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, dm_rdata = 0;
    logic ready, rsp_valid, rsp_err, stall, wr_req, rd_req;
    logic [31:0] rsp_rdata, dmaddr, dmdata;
    logic [3:0] mask;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    int passed = 0, total = 0;
    logic [31:0] cap_a [2];
    logic [31:0] cap_d [2];
    logic [3:0] cap_m [2];
    logic [31:0] cap_rdata;
    logic cap_err;

    msrv32_lsu_hs #(.DW(32), .AW(32), .TIMEOUT_CYC(TO)) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .req_valid_in(req_valid), .req_ready_out(ready), .req_we_in(req_we),
        .req_size_in(req_size), .req_unsigned_in(req_uns), .req_addr_in(req_addr),
        .req_wdata_in(req_wdata), .flush_in(flush), .rsp_valid_out(rsp_valid),
        .rsp_rdata_out(rsp_rdata), .rsp_err_out(rsp_err), .stall_out(stall),
        .ms_riscv32_mp_dmaddr_out(dmaddr), .ms_riscv32_mp_dmdata_out(dmdata),
        .ms_riscv32_mp_dmwr_mask_out(mask), .ms_riscv32_mp_dmwr_req_out(wr_req),
        .ms_riscv32_mp_dmrd_req_out(rd_req), .ms_riscv32_mp_dmack_in(ack),
        .ms_riscv32_mp_dmdata_in(dm_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, got, exp);
    endtask

    function automatic logic [31:0] bm(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        mem[a] = d;
        ref_mem[a] = d;
    endtask

    // one access end to end; beat k is acked after dly[k] wait cycles (>= TO means never)
    task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int d0, input int d1);
        int bytes, off, nb, lat, done, k, w, rqn;
        int dly [2];
        logic errp, to;
        logic [31:0] ea [2];
        logic [31:0] ed [2];
        logic [3:0] em [2];
        logic [63:0] v;
        logic [31:0] exp_rd;
        logic [7:0] ai;
        bytes = 1 << size;
        off = int'(addr & 32'h3);
        dly[0] = d0;
        dly[1] = d1;
        errp = size == 2'd3;
`ifdef MSRV32_LSU_MISALIGN_SPLIT_EN
        nb = errp ? 0 : (off + bytes > 4 ? 2 : 1);
`else
        errp = errp || (addr % bytes != 0);
        nb = errp ? 0 : 1;
`endif
        lat = 1;
        done = 0;
        to = 0;
        for (int b = 0; b < nb; b++) begin
            if (dly[b] >= TO) begin
                lat += TO;
                to = 1;
                break;
            end
            lat += dly[b] + 1;
            done++;
        end
        for (int b = 0; b < 2; b++) begin
            ea[b] = (addr & ~32'h3) + 32'(4 * b);
            em[b] = 0;
            ed[b] = 0;
        end
        v = 0;
        if (!errp) begin
            for (int i = 0; i < bytes; i++) begin
                int ln;
                ln = off + i;
                em[ln / 4][ln % 4] = 1'b1;
                ed[ln / 4][8 * (ln % 4) +: 8] = wdata[8 * i +: 8];
                ai = 8'(addr + 32'(i));
                v[8 * i +: 8] = ref_mem[ai];
            end
            if (!uns && v[8 * bytes - 1]) v = v | ~((64'd1 << (8 * bytes)) - 64'd1);
        end
        exp_rd = (we || errp || to) ? 32'h0 : v[31:0];
        @(negedge clk);
        chk("ready_before_req", ready, 1);
        req_valid = 1;
        req_we = we;
        req_size = size;
        req_uns = uns;
        req_addr = addr;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 0;
        k = 0;
        w = 0;
        rqn = 0;
        for (int c = 1; c <= lat + 1; c++) begin
            ack = 0;
            chk("rsp_valid_timing", rsp_valid, c == lat);
            chk("stall", stall, c <= lat);
            chk("req_ready", ready, c > lat);
            if (c == lat) begin
                cap_rdata = rsp_rdata;
                cap_err = rsp_err;
                chk("rsp_err", rsp_err, errp || to);
                chk("rsp_rdata", rsp_rdata, exp_rd);
            end
            if (wr_req || rd_req) begin
                rqn++;
                if (k < nb) begin
                    if (w == 0) begin
                        cap_a[k] = dmaddr;
                        cap_m[k] = mask;
                        cap_d[k] = dmdata;
                    end
                    chk("beat_addr", dmaddr, ea[k]);
                    chk("beat_mask", mask, em[k]);
                    chk("beat_dir", {wr_req, rd_req}, {we, !we});
                    if (we) chk("beat_wdata", dmdata & bm(em[k]), ed[k]);
                    if (w == dly[k]) begin
                        ai = dmaddr[7:0];
                        ack = 1;
                        dm_rdata = {mem[ai + 8'd3], mem[ai + 8'd2], mem[ai + 8'd1], mem[ai]};
                        if (wr_req)
                            for (int j = 0; j < 4; j++)
                                if (mask[j]) mem[ai + 8'(j)] = dmdata[8 * j +: 8];
                        k++;
                        w = 0;
                    end else begin
                        w++;
                    end
                end
            end
            @(negedge clk);
        end
        ack = 0;
        chk("req_cycles", rqn, nb != 0 ? lat - 1 : 0);
        if (we && !errp)
            for (int i = 0; i < bytes; i++)
                if ((off + i) / 4 < done) begin
                    ai = 8'(addr + 32'(i));
                    ref_mem[ai] = wdata[8 * i +: 8];
                end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_reqs", {wr_req, rd_req}, 0);
        chk("rst_dmaddr", dmaddr, 0);
        chk("rst_mask", mask, 0);
        chk("rst_rdata", rsp_rdata, 0);

        poke(8'h00, 8'hEF); poke(8'h01, 8'hBE); poke(8'h02, 8'hAD); poke(8'h03, 8'hDE);
        txn(0, 2'd2, 0, 32'h100, 0, 3, 0);
        chk("lit_lw_rdata", cap_rdata, 32'hDEADBEEF);
        chk("lit_lw_err", cap_err, 0);

        txn(1, 2'd0, 0, 32'h103, 32'hA5, 0, 0);
        chk("lit_sb_addr", cap_a[0], 32'h100);
        chk("lit_sb_mask", cap_m[0], 4'b1000);
        chk("lit_sb_data", cap_d[0], 32'hA5000000);

        poke(8'h00, 8'h00); poke(8'h01, 8'h00); poke(8'h02, 8'h01); poke(8'h03, 8'h80);
        txn(0, 2'd1, 0, 32'h102, 0, 1, 0);
        chk("lit_lh_signed", cap_rdata, 32'hFFFF8001);
        txn(0, 2'd1, 1, 32'h102, 0, 0, 0);
        chk("lit_lhu", cap_rdata, 32'h00008001);

        poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB);
        txn(0, 2'd2, 0, 32'h0FE, 0, 1, 2);
`ifdef MSRV32_LSU_MISALIGN_SPLIT_EN
        chk("lit_split_a0", cap_a[0], 32'h0FC);
        chk("lit_split_m0", cap_m[0], 4'b1100);
        chk("lit_split_a1", cap_a[1], 32'h100);
        chk("lit_split_m1", cap_m[1], 4'b0011);
        chk("lit_split_rdata", cap_rdata, 32'h0000BBAA);
        chk("lit_split_err", cap_err, 0);
`else
        chk("lit_misal_err", cap_err, 1);
        chk("lit_misal_rdata", cap_rdata, 0);
`endif

        txn(0, 2'd2, 0, 32'h200, 0, 9, 0);
        chk("lit_timeout_err", cap_err, 1);
        chk("lit_timeout_rdata", cap_rdata, 0);

        txn(0, 2'd3, 0, 32'h100, 0, 0, 0);
        chk("lit_size_d_err", cap_err, 1);

        for (int n = 0; n < 300; n++) begin
            logic [1:0] sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 3));
            a = $urandom & 32'h3FF;
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << sz) - 32'd1);
            txn(1'($urandom), sz, 1'($urandom), a, $urandom,
                $urandom_range(0, 7) == 0 ? 6 : $urandom_range(0, 3),
                $urandom_range(0, 7) == 0 ? 6 : $urandom_range(0, 3));
        end

        @(negedge clk);
        req_valid = 1; req_we = 0; req_size = 2'd2; req_addr = 32'h100;
        @(negedge clk);
        req_valid = 0;
        chk("fl_ack_req_up", rd_req, 1);
        ack = 1; flush = 1; dm_rdata = 32'h12345678;
        @(negedge clk);
        ack = 0; flush = 0;
        chk("fl_ack_req_drop", rd_req, 0);
        chk("fl_ack_ready", ready, 1);
        chk("fl_ack_no_rsp", rsp_valid, 0);
        repeat (3) begin
            @(negedge clk);
            chk("fl_ack_quiet", rsp_valid, 0);
            chk("fl_ack_idle", stall, 0);
        end

        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h104; flush = 1;
        @(negedge clk);
        req_valid = 0; flush = 0;
        chk("fl_acc_noreq", {wr_req, rd_req}, 0);
        chk("fl_acc_ready", ready, 1);
        @(negedge clk);
        chk("fl_acc_no_rsp", rsp_valid, 0);

        req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h108;
        @(negedge clk);
        req_valid = 0;
        chk("rst_mid_req_up", wr_req, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst_mid_req_drop", wr_req, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_no_rsp", rsp_valid, 0);
        @(negedge clk);
        chk("rst_mid_quiet", rsp_valid, 0);

        txn(0, 2'd2, 0, 32'h104, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
